// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and default width.
package div_pkg;
  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {rem, quo} left, subtract the divisor magnitude when it fits.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div_mag,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // The extra top bit keeps the compare exact even though rem never exceeds WIDTH bits in use.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {2'b00, i_div_mag});
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_div_mag};

  assign o_rem = w_ge ? w_diff : w_shift[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divider_iter_sdu.sv
// Multi-cycle signed/unsigned restoring divider with divide-by-zero fast path and done pulse.
module divider_iter_sdu
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk_in,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  div_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH:0]   r_rem, w_rem_next;
  logic [WIDTH-1:0] r_quo, w_quo_next;
  logic [WIDTH-1:0] r_div_mag, w_div_mag_next;
  logic             r_sign_q, w_sign_q_next;
  logic             r_sign_r, w_sign_r_next;
  logic [WIDTH-1:0] r_quotient, w_quotient_next;
  logic [WIDTH-1:0] r_remainder, w_remainder_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_dbz, w_dbz_next;

  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_dvd_neg;
  logic             w_dvs_neg;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_div_mag (r_div_mag),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Unsigned mode never negates, so an MSB-set operand stays a large positive value.
  assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_rem_next       = r_rem;
    w_quo_next       = r_quo;
    w_div_mag_next   = r_div_mag;
    w_sign_q_next    = r_sign_q;
    w_sign_r_next    = r_sign_r;
    w_quotient_next  = r_quotient;
    w_remainder_next = r_remainder;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_dbz_next       = r_dbz;

    case (r_state)
      DIV_IDLE: begin
        if (i_start) begin
          if (i_divisor == '0) begin
            w_quotient_next  = '1;
            w_remainder_next = i_dividend;
            w_dbz_next       = 1'b1;
            w_done_next      = 1'b1;
          end else begin
            w_rem_next     = '0;
            w_quo_next     = w_dvd_mag;
            w_div_mag_next = w_dvs_mag;
            w_sign_q_next  = w_dvd_neg ^ w_dvs_neg;
            w_sign_r_next  = w_dvd_neg;
            w_cnt_next     = '0;
            w_busy_next    = 1'b1;
            w_state_next   = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        w_rem_next = w_step_rem;
        w_quo_next = w_step_quo;
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        // MIN / -1 yields quo = 2^(WIDTH-1); negating it wraps back to MIN.
        w_quotient_next  = r_sign_q ? -r_quo : r_quo;
        w_remainder_next = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_dbz_next       = 1'b0;
        w_done_next      = 1'b1;
        w_busy_next      = 1'b0;
        w_state_next     = DIV_IDLE;
      end
      default: begin
        w_state_next = DIV_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div_mag   <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rem       <= w_rem_next;
      r_quo       <= w_quo_next;
      r_div_mag   <= w_div_mag_next;
      r_sign_q    <= w_sign_q_next;
      r_sign_r    <= w_sign_r_next;
      r_quotient  <= w_quotient_next;
      r_remainder <= w_remainder_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_dbz       <= w_dbz_next;
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_iter_sdu.sv
// Self-checking bench: WIDTH=32 and WIDTH=8 instances checked against an arithmetic reference model.
module tb_divider_iter_sdu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_start, s_sgn;
  logic [31:0] s_a, s_b;
  logic [31:0] q32, r32;
  logic        busy32, done32, dbz32;

  logic        e_start, e_sgn;
  logic [7:0]  e_a, e_b;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dbz8;

  int checks = 0;
  int errors = 0;

  divider_iter_sdu #(.WIDTH(32)) dut32 (
    .i_clk_in(clk), .i_reset(rst), .i_start(s_start), .i_is_signed(s_sgn),
    .i_dividend(s_a), .i_divisor(s_b), .o_quotient(q32), .o_remainder(r32),
    .o_busy(busy32), .o_done(done32), .o_div_by_zero(dbz32)
  );

  divider_iter_sdu #(.WIDTH(8)) dut8 (
    .i_clk_in(clk), .i_reset(rst), .i_start(e_start), .i_is_signed(e_sgn),
    .i_dividend(e_a), .i_divisor(e_b), .o_quotient(q8), .o_remainder(r8),
    .o_busy(busy8), .o_done(done8), .o_div_by_zero(dbz8)
  );

  // Truncating division on sign-extended 64-bit values; remainder follows the dividend sign.
  function automatic void model(input int w, input bit sgn, input longint unsigned a,
                                input longint unsigned b, output longint unsigned q,
                                output longint unsigned r);
    longint unsigned mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if (b == 0) begin
      q = mask;
      r = a & mask;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      q = longint'(sa / sb) & mask;
      r = longint'(sa % sb) & mask;
    end
  endfunction

  task automatic start32(input logic sg, input logic [31:0] a, input logic [31:0] b);
    s_start = 1'b1; s_sgn = sg; s_a = a; s_b = b;
  endtask

  task automatic finish32(output logic [31:0] q, output logic [31:0] r, output logic dz,
                          output int n, output int bc);
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 1; bc = 0;
    while (!done32 && n < 200) begin
      if (busy32) bc++;
      @(posedge clk); #1;
      n++;
    end
    if (!done32) begin
      checks++; errors++;
      $display("FAIL timeout32: no done after %0d edges, required done=1", n);
    end
    q = q32; r = r32; dz = dbz32;
  endtask

  task automatic op32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r, output logic dz,
                      output int n, output int bc);
    @(posedge clk); #1;
    start32(sg, a, b);
    finish32(q, r, dz, n, bc);
    $display("op32 sgn=%0d a=%h b=%h -> q=%h r=%h dbz=%0d edges=%0d", sg, a, b, q, r, dz, n);
  endtask

  task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r, output logic dz,
                     output int n);
    @(posedge clk); #1;
    e_start = 1'b1; e_sgn = sg; e_a = a; e_b = b;
    @(posedge clk); #1;
    e_start = 1'b0;
    n = 1;
    while (!done8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done8) begin
      checks++; errors++;
      $display("FAIL timeout8: no done after %0d edges, required done=1", n);
    end
    q = q8; r = r8; dz = dbz8;
    $display("op8 sgn=%0d a=%h b=%h -> q=%h r=%h dbz=%0d edges=%0d", sg, a, b, q, r, dz, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_start = 0; s_sgn = 0; s_a = 0; s_b = 0;
    e_start = 0; e_sgn = 0; e_a = 0; e_b = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({q32, r32, busy32, done32, dbz32} !== 67'd0) begin
      errors++;
      $display("FAIL reset32: got q=%h r=%h busy=%b done=%b dbz=%b, required all 0",
               q32, r32, busy32, done32, dbz32);
    end
    checks++;
    if ({q8, r8, busy8, done8, dbz8} !== 19'd0) begin
      errors++;
      $display("FAIL reset8: got q=%h r=%h busy=%b done=%b dbz=%b, required all 0",
               q8, r8, busy8, done8, dbz8);
    end
    rst = 1'b0;
    $display("reset applied and released");
  endtask

  task automatic test_unsigned;
    logic [31:0] q, r, a, b;
    logic dz;
    int n, bc;
    longint unsigned mq, mr;
    op32(1'b0, 32'd100, 32'd7, q, r, dz, n, bc);
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL u100_7_q: got %h required %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL u100_7_r: got %h required %h", r, 32'd2); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL u100_7_dbz: got %b required 0", dz); end
    checks++; if (n != 34) begin errors++; $display("FAIL u100_7_latency: got %0d edges required 34", n); end
    checks++; if (bc != 33) begin errors++; $display("FAIL u100_7_busy: got %0d busy cycles required 33", bc); end
    @(posedge clk); #1;
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%b required 0", done32); end
    for (int i = 0; i < 15; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      op32(1'b0, a, b, q, r, dz, n, bc);
      model(32, 1'b0, 64'(a), 64'(b), mq, mr);
      checks++;
      if (q !== 32'(mq) || r !== 32'(mr) || dz !== (b == 0)) begin
        errors++;
        $display("FAIL urand: a=%h b=%h got q=%h r=%h dbz=%b required q=%h r=%h",
                 a, b, q, r, dz, 32'(mq), 32'(mr));
      end
    end
  endtask

  task automatic test_signed;
    logic [31:0] q, r, a, b;
    logic dz;
    int n, bc;
    longint unsigned mq, mr;
    op32(1'b1, 32'hFFFFFF9C, 32'd7, q, r, dz, n, bc);
    checks++; if ({q, r} !== {32'hFFFFFFF2, 32'hFFFFFFFE}) begin errors++;
      $display("FAIL sneg100_7: got q=%h r=%h required q=fffffff2 r=fffffffe", q, r); end
    op32(1'b1, 32'd100, 32'hFFFFFFF9, q, r, dz, n, bc);
    checks++; if ({q, r} !== {32'hFFFFFFF2, 32'd2}) begin errors++;
      $display("FAIL s100_neg7: got q=%h r=%h required q=fffffff2 r=00000002", q, r); end
    op32(1'b0, 32'hFFFFFFFF, 32'd2, q, r, dz, n, bc);
    checks++; if ({q, r} !== {32'h7FFFFFFF, 32'd1}) begin errors++;
      $display("FAIL uffff_2: got q=%h r=%h required q=7fffffff r=00000001", q, r); end
    for (int i = 0; i < 15; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      op32(1'b1, a, b, q, r, dz, n, bc);
      model(32, 1'b1, 64'(a), 64'(b), mq, mr);
      checks++;
      if (q !== 32'(mq) || r !== 32'(mr) || dz !== (b == 0)) begin
        errors++;
        $display("FAIL srand: a=%h b=%h got q=%h r=%h dbz=%b required q=%h r=%h",
                 a, b, q, r, dz, 32'(mq), 32'(mr));
      end
    end
  endtask

  task automatic test_edges;
    logic [31:0] q, r;
    logic dz;
    int n, bc;
    op32(1'b0, 32'h1234, 32'd0, q, r, dz, n, bc);
    checks++; if ({q, r, dz} !== {32'hFFFFFFFF, 32'h1234, 1'b1}) begin errors++;
      $display("FAIL div0_u: got q=%h r=%h dbz=%b required q=ffffffff r=00001234 dbz=1", q, r, dz); end
    checks++; if (n != 1 || bc != 0) begin errors++;
      $display("FAIL div0_timing: got %0d edges, %0d busy cycles required 1 and 0", n, bc); end
    op32(1'b1, 32'h1234, 32'd0, q, r, dz, n, bc);
    checks++; if ({q, r, dz} !== {32'hFFFFFFFF, 32'h1234, 1'b1}) begin errors++;
      $display("FAIL div0_s: got q=%h r=%h dbz=%b required q=ffffffff r=00001234 dbz=1", q, r, dz); end
    op32(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, dz, n, bc);
    checks++; if ({q, r, dz} !== {32'h80000000, 32'd0, 1'b0}) begin errors++;
      $display("FAIL overflow: got q=%h r=%h dbz=%b required q=80000000 r=0 dbz=0", q, r, dz); end
  endtask

  task automatic test_ignore_start;
    int n;
    @(posedge clk); #1;
    start32(1'b0, 32'd1000, 32'd3);
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 1;
    repeat (5) begin @(posedge clk); #1; n++; end
    start32(1'b1, 32'd77, 32'hFFFFFFFB);
    @(posedge clk); #1;
    n++;
    s_start = 1'b0; s_a = 32'hDEADBEEF; s_b = 32'd9;
    while (!done32 && n < 200) begin @(posedge clk); #1; n++; end
    $display("ignore_start: q=%h r=%h edges=%0d", q32, r32, n);
    checks++; if ({q32, r32} !== {32'd333, 32'd1}) begin errors++;
      $display("FAIL ignore_start: got q=%h r=%h required q=0000014d r=00000001", q32, r32); end
    checks++; if (n != 34) begin errors++; $display("FAIL ignore_latency: got %0d edges required 34", n); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r;
    logic dz;
    int n, bc;
    op32(1'b1, 32'hFFFFFFCE, 32'd6, q, r, dz, n, bc);
    checks++; if ({q, r} !== {32'hFFFFFFF8, 32'hFFFFFFFE}) begin errors++;
      $display("FAIL b2b_first: got q=%h r=%h required q=fffffff8 r=fffffffe", q, r); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL b2b_busy: got busy=%b required 0", busy32); end
    start32(1'b0, 32'd1000, 32'd10);
    finish32(q, r, dz, n, bc);
    $display("b2b second: q=%h r=%h edges=%0d", q, r, n);
    checks++; if ({q, r} !== {32'd100, 32'd0}) begin errors++;
      $display("FAIL b2b_second: got q=%h r=%h required q=00000064 r=0", q, r); end
    checks++; if (n != 34) begin errors++; $display("FAIL b2b_latency: got %0d edges required 34", n); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    logic dz;
    int n, bc, dcnt;
    @(posedge clk); #1;
    start32(1'b0, 32'd123456, 32'd789);
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-run: busy=%b q=%h r=%h", busy32, q32, r32);
    checks++; if ({busy32, done32, q32, r32} !== 66'd0) begin errors++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h required all 0", busy32, done32, q32, r32); end
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done32) dcnt++; end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL reset_nodone: got %0d done cycles required 0", dcnt); end
    op32(1'b0, 32'd9, 32'd3, q, r, dz, n, bc);
    checks++; if ({q, r} !== {32'd3, 32'd0}) begin errors++;
      $display("FAIL after_reset: got q=%h r=%h required q=3 r=0", q, r); end
  endtask

  task automatic test_width8;
    logic [7:0] q, r, a, b;
    logic dz;
    int n;
    longint unsigned mq, mr;
    op8(1'b0, 8'd255, 8'd16, q, r, dz, n);
    checks++; if ({q, r} !== {8'd15, 8'd15}) begin errors++;
      $display("FAIL w8_255_16: got q=%h r=%h required q=0f r=0f", q, r); end
    checks++; if (n != 10) begin errors++; $display("FAIL w8_latency: got %0d edges required 10", n); end
    op8(1'b1, 8'h80, 8'hFF, q, r, dz, n);
    checks++; if ({q, r, dz} !== {8'h80, 8'h00, 1'b0}) begin errors++;
      $display("FAIL w8_overflow: got q=%h r=%h dbz=%b required q=80 r=00 dbz=0", q, r, dz); end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      e_sgn = 1'($urandom);
      op8(e_sgn, a, b, q, r, dz, n);
      model(8, e_sgn, 64'(a), 64'(b), mq, mr);
      checks++;
      if (q !== 8'(mq) || r !== 8'(mr) || dz !== (b == 0)) begin
        errors++;
        $display("FAIL w8rand: a=%h b=%h got q=%h r=%h dbz=%b required q=%h r=%h",
                 a, b, q, r, dz, 8'(mq), 8'(mr));
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_edges;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_width8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
